// File: rtl/cache_axi_rd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cache_axi_rd_arbiter_pkg
//   Shared definitions for the icache/dcache AXI read arbiter:
//     - FSM state encoding (IDLE/ADDR/DATA)
//     - AXI transaction IDs used to tag each requester
//     - fixed AR attributes (4-byte beats, INCR bursts)
//   No ports; imported by cache_axi_rd_arbiter and arb_pick.
// ---------------------------------------------------------------------------
package cache_axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b11
  } state_e;

  localparam logic [3:0] ID_ICACHE      = 4'd0;
  localparam logic [3:0] ID_DCACHE      = 4'd1;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Bit positions in the request/grant vectors.
  localparam int unsigned REQ_I = 0;
  localparam int unsigned REQ_D = 1;

  // Map the 1-bit grant (1 = dcache) to the AXI id for that requester.
  function automatic logic [3:0] id_of(input logic grant_d);
    return grant_d ? ID_DCACHE : ID_ICACHE;
  endfunction

endpackage

// File: rtl/cache_axi_rd_arbiter_arb_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
//   Combinational requester picker for the cache AXI read arbiter.
//   Ports:
//     req_i[1:0]    request vector, bit0 = icache, bit1 = dcache
//     last_grant_i  requester granted last time (1 = dcache)
//     gnt_o[1:0]    one-hot grant, zero when nothing requests
//   Policy macro ARB_ROUND_ROBIN_EN:
//     defined   -> on a tie the requester not granted last wins
//     undefined -> fixed priority, dcache over icache
// ---------------------------------------------------------------------------
module arb_pick
  import cache_axi_rd_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    gnt_o = req_i;
    // Tie: hand the bus to whoever did not have it last.
    if (req_i == 2'b11) begin
      gnt_o = last_grant_i ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[REQ_D]) begin
      gnt_o[REQ_D] = 1'b1;
    end else if (req_i[REQ_I]) begin
      gnt_o[REQ_I] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/cache_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// cache_axi_rd_arbiter
//   Shares one AXI read channel (AR + R) between the icache and the dcache.
//   One burst is in flight at a time; the granted requester owns AR and R
//   until the rlast handshake. Each burst is tagged with arid (0 = icache,
//   1 = dcache) and the returned id / burst length are checked; any
//   violation sets the sticky err flag.
//   Ports:
//     clk, rst                       clock, async active-high reset
//     i_ar*/i_r*                     icache request/response side
//     d_ar*/d_r*                     dcache request/response side
//     m_ar*/m_r*                     AXI master read port
//     err                            sticky protocol error
//     dbg_state_o                    current FSM state (IDLE/ADDR/DATA)
//   Config macro ARB_ROUND_ROBIN_EN: defined -> round-robin on ties
//   (last_grant register, resets to icache); undefined -> dcache always
//   wins a tie.
// ---------------------------------------------------------------------------
module cache_axi_rd_arbiter
  import cache_axi_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  // icache side
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic [LEN_W-1:0]  i_arlen,
  input  logic              i_arvalid,
  output logic              i_arready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rlast,
  output logic              i_rvalid,
  input  logic              i_rready,
  // dcache side
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic [LEN_W-1:0]  d_arlen,
  input  logic              d_arvalid,
  output logic              d_arready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rlast,
  output logic              d_rvalid,
  input  logic              d_rready,
  // AXI master read port
  output logic [3:0]        m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [LEN_W-1:0]  m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [3:0]        m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  // status
  output logic              err,
  output logic [1:0]        dbg_state_o
);

  // Handshake rule on every channel here: a transfer happens on a rising
  // edge where valid and ready are both high; valid never waits on ready,
  // and ready/valid toward a requester are only ever passed through for the
  // currently granted requester, the other side sees zeros.

  state_e           state_q;
  logic             grant_q;      // 1 = dcache owns the channel
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt_q;
  logic             err_q;

  logic [1:0]       req;
  logic [1:0]       gnt;
  logic             last_grant;
  logic             in_addr;
  logic             in_data;
  logic             ar_hs;
  logic             r_hs;
  logic             rid_bad;
  logic             len_bad;

`ifdef ARB_ROUND_ROBIN_EN
  logic             last_grant_q;
  assign last_grant = last_grant_q;
`else
  assign last_grant = 1'b0;
`endif

  assign req[REQ_I] = i_arvalid;
  assign req[REQ_D] = d_arvalid;

  arb_pick u_arb_pick (
    .req_i        (req),
    .last_grant_i (last_grant),
    .gnt_o        (gnt)
  );

  assign in_addr = (state_q == ADDR);
  assign in_data = (state_q == DATA);

  // AR channel follows the granted requester. The grant is held through
  // ADDR even if that requester drops arvalid.
  assign m_arid    = id_of(grant_q);
  assign m_araddr  = grant_q ? d_araddr : i_araddr;
  assign m_arlen   = grant_q ? d_arlen  : i_arlen;
  assign m_arsize  = AXI_SIZE_4B;
  assign m_arburst = AXI_BURST_INCR;
  assign m_arvalid = in_addr & (grant_q ? d_arvalid : i_arvalid);
  assign i_arready = in_addr & ~grant_q & m_arready;
  assign d_arready = in_addr &  grant_q & m_arready;

  // R channel: data fans out to both, valid/last only to the owner.
  assign m_rready  = in_data & (grant_q ? d_rready : i_rready);
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;
  assign i_rvalid  = in_data & ~grant_q & m_rvalid;
  assign d_rvalid  = in_data &  grant_q & m_rvalid;
  assign i_rlast   = in_data & ~grant_q & m_rlast;
  assign d_rlast   = in_data &  grant_q & m_rlast;

  assign ar_hs = m_arvalid & m_arready;
  assign r_hs  = in_data & m_rvalid & m_rready;

  // beat_cnt_q counts beats already accepted, so the final beat of a
  // burst of len_q+1 beats arrives with beat_cnt_q == len_q.
  assign rid_bad = (m_rid != m_arid);
  assign len_bad = m_rlast ? (beat_cnt_q != len_q) : (beat_cnt_q == len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            grant_q      <= gnt[REQ_D];
            len_q        <= gnt[REQ_D] ? d_arlen : i_arlen;
            state_q      <= ADDR;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= gnt[REQ_D];
`endif
          end
        end
        ADDR: begin
          if (ar_hs) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            if (rid_bad || len_bad) begin
              err_q <= 1'b1;
            end
            if (m_rlast) begin
              state_q    <= IDLE;
              beat_cnt_q <= '0;
            end else begin
              beat_cnt_q <= beat_cnt_q + LEN_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule
